fb_uart_loader: RTL and testbench

- Serial framebuffer loader. Receives frames over a PMOD UART pin and writes 4-bit pixels into the back bank of the double-banked pixel memory that the pixel fetch interface reads from.
- Sits directly upstream of the pixel memory write port.
- On a completed frame it requests a bank swap, so the display switches to the new image cleanly.

---
 rtl/fb_uart_loader_pkg.sv | 33 +++
 rtl/fb_uart_loader_if.sv | 16 +
 rtl/fb_uart_loader_uart_rx.sv | 98 +++++++++
 rtl/fb_uart_loader.sv | 195 +++++++++++++++++++
 tb/tb_fb_uart_loader.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_uart_loader_pkg.sv
// Shared types and constants for the serial framebuffer loader.
// The command FSM, the UART receiver and the bench all import this package.
package fb_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LOAD,
    FILL_WAIT,
    FILL,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_FILL  = 8'h02;

  localparam int PIX_ADDR_W_DEF = 12;
  localparam int PIX_COUNT      = 2 ** PIX_ADDR_W_DEF;

  // Pixel count for a non-default bank address width.
  function automatic int pix_count(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage

// File: rtl/fb_uart_loader_if.sv
// Pixel memory write port plus the bank swap request.
// wr_en qualifies wr_bank/wr_addr/wr_data for exactly one cycle with no ready:
// the memory accepts every write; swap_req is a one-cycle pulse after the last write.
interface fb_wr_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
);
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              swap_req;

  modport master (output wr_en, wr_bank, wr_addr, wr_data, swap_req);
  modport slave  (input  wr_en, wr_bank, wr_addr, wr_data, swap_req);
endinterface

// File: rtl/fb_uart_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, glitch-checked start bit, centre sampling.
// byte_valid / frame_err pulse one cycle after the stop-bit sample.
module uart_rx
  import fb_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 126
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  output logic [7:0] data,
  output logic      byte_valid,
  output logic      frame_err,
  output rx_state_t dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state_q, state_d;
  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_s3_q && !rx_s2_q) state_d = RX_START;
      end
      RX_START: begin
        // A line that is high again at mid-start was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          valid_d = rx_s2_q;
          ferr_d  = !rx_s2_q;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data       = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;
  assign dbg_state  = state_q;

endmodule

// File: rtl/fb_uart_loader.sv
// Serial framebuffer loader: decodes A5/LOAD and A5/FILL frames from the UART
// and writes pixels into the back bank, then requests a bank swap.
module fb_uart_loader
  import fb_loader_pkg::*;
#(
  parameter int CLK_HZ       = 126000000,
  parameter int BAUD         = 1000000,
  parameter int PIX_ADDR_W   = 12,
  parameter int PIX_W        = 4,
  parameter int TIMEOUT_CLKS = 20 * 10 * (CLK_HZ / BAUD)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  input  logic      disp_bank,
  fb_wr_if.master   wr,
  output logic      busy,
  output logic      err,
  output state_t    dbg_state,
  output rx_state_t dbg_rx_state
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TMO_W        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [PIX_ADDR_W-1:0] LAST_ADDR = PIX_ADDR_W'(pix_count(PIX_ADDR_W) - 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (rx_data),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr),
    .dbg_state (dbg_rx_state)
  );

  state_t                state_q, state_d;
  logic [PIX_ADDR_W-1:0] addr_q, addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [PIX_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]      wr_data_q, wr_data_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  lo_pend_q, lo_pend_d;
  logic [PIX_W-1:0]      lo_nib_q, lo_nib_d;
  logic [PIX_W-1:0]      colour_q, colour_d;
  logic                  swap_q, swap_d;
  logic                  err_q, err_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  timed_out;

  assign timed_out = (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_bank_d = wr_bank_q;
    lo_pend_d = 1'b0;
    lo_nib_d  = lo_nib_q;
    colour_d  = colour_q;
    swap_d    = 1'b0;
    err_d     = err_q | rx_ferr;
    tmo_d     = '0;
    case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_d = CMD;
      end
      CMD: begin
        tmo_d = tmo_q + 1'b1;
        if (rx_ferr) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          tmo_d  = '0;
          addr_d = '0;
          if (rx_data == CMD_LOAD) begin
            state_d   = LOAD;
            wr_bank_d = ~disp_bank;
          end else if (rx_data == CMD_FILL) begin
            state_d   = FILL_WAIT;
            wr_bank_d = ~disp_bank;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end else if (timed_out) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      LOAD: begin
        tmo_d = tmo_q + 1'b1;
        // Low nibble goes out the cycle after the high nibble of the same byte.
        if (lo_pend_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = lo_nib_q;
          addr_d    = addr_q + 1'b1;
        end else if (wr_en_q && wr_addr_q == LAST_ADDR) begin
          state_d = DONE;
          swap_d  = 1'b1;
        end else if (rx_ferr) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          tmo_d     = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = PIX_W'(rx_data[7:4]);
          lo_nib_d  = PIX_W'(rx_data[3:0]);
          lo_pend_d = 1'b1;
          addr_d    = addr_q + 1'b1;
        end else if (timed_out) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      FILL_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // Pixel 0 is issued on the way into FILL so FILL spans exactly one cycle per pixel.
        if (rx_ferr) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          state_d   = FILL;
          colour_d  = PIX_W'(rx_data[3:0]);
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = PIX_W'(rx_data[3:0]);
          addr_d    = PIX_ADDR_W'(1);
        end else if (timed_out) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      FILL: begin
        if (wr_addr_q == LAST_ADDR) begin
          state_d = DONE;
          swap_d  = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = colour_q;
          addr_d    = addr_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_bank_q <= 1'b0;
      lo_pend_q <= 1'b0;
      lo_nib_q  <= '0;
      colour_q  <= '0;
      swap_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_bank_q <= wr_bank_d;
      lo_pend_q <= lo_pend_d;
      lo_nib_q  <= lo_nib_d;
      colour_q  <= colour_d;
      swap_q    <= swap_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign wr.wr_en    = wr_en_q;
  assign wr.wr_bank  = wr_bank_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign wr.swap_req = swap_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fb_uart_loader.sv
// Directed bench for fb_uart_loader with a queue-based model of the expected pixel writes.
// Runs at 8 clocks per bit with 1024-pixel banks to keep the run short.
`timescale 1ns/1ps
module tb_fb_uart_loader;
  import fb_loader_pkg::*;

  localparam int CLK_HZ = 8000000;
  localparam int BAUD   = 1000000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int AW     = 10;
  localparam int PW     = 4;
  localparam int N_PIX  = 2 ** AW;
  localparam int TMO    = 20 * 10 * CPB;
  localparam int EW     = 1 + AW + PW;

  logic      clk = 1'b0;
  logic      rst;
  logic      rx;
  logic      disp_bank;
  logic      busy;
  logic      err;
  state_t    dbg_state;
  rx_state_t dbg_rx_state;

  fb_wr_if #(.ADDR_W(AW), .DATA_W(PW)) wr ();

  fb_uart_loader #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .PIX_ADDR_W  (AW),
    .PIX_W       (PW),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .disp_bank   (disp_bank),
    .wr          (wr),
    .busy        (busy),
    .err         (err),
    .dbg_state   (dbg_state),
    .dbg_rx_state(dbg_rx_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required<95000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  logic [EW-1:0] exp_q[$];
  logic [PW-1:0] shadow [0:2*N_PIX-1];
  int   exp_swaps = 0;
  int   swaps_seen = 0;
  int   n_writes = 0;
  int   bv_cnt = 0;
  logic [7:0] bv_last = 8'h00;
  bit   mon_en = 1'b0;
  bit   prev_wr_en = 1'b0;
  int   first_wr_cyc = -1;
  int   last_wr_cyc = -1;

  // Model: byte k of a LOAD carries pixels 2k (high nibble) and 2k+1 (low nibble).
  task automatic push_load(input logic bank, input int nbytes);
    logic [7:0] b;
    for (int k = 0; k < nbytes; k++) begin
      b = 8'(k);
      exp_q.push_back({bank, AW'(2 * k), b[7:4]});
      exp_q.push_back({bank, AW'(2 * k + 1), b[3:0]});
    end
  endtask

  task automatic push_fill(input logic bank, input logic [PW-1:0] colour, input int npix);
    for (int a = 0; a < npix; a++) exp_q.push_back({bank, AW'(a), colour});
  endtask

  // Compare process: every write against the model queue, every swap against its timing rule.
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    if (mon_en) begin
      if (dut.u_rx.byte_valid === 1'b1) begin
        bv_cnt++;
        bv_last = dut.u_rx.data;
      end
      if (wr.wr_en === 1'b1) begin
        got = {wr.wr_bank, wr.wr_addr, wr.wr_data};
        n_writes++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_write", 32'(got), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check(got == e, "write", 32'(got), 32'(e));
        end
        shadow[{wr.wr_bank, wr.wr_addr}] = wr.wr_data;
      end
      if (wr.swap_req === 1'b1) begin
        swaps_seen++;
        check(exp_swaps > 0 && exp_q.size() == 0 && prev_wr_en, "swap_req_timing",
              {30'(exp_q.size()), 1'(exp_swaps > 0), 1'(prev_wr_en)}, 32'h1);
        if (exp_swaps > 0) exp_swaps--;
      end
      prev_wr_en = (wr.wr_en === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rx_bit(input logic v);
    @(negedge clk);
    rx = v;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(good_stop);
    if (!good_stop) rx_bit(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_swaps(input int target, input int budget, input string name);
    for (int i = 0; i < budget && swaps_seen < target; i++) @(negedge clk);
    check(swaps_seen == target, name, 32'(swaps_seen), 32'(target));
  endtask

  task automatic check_pix(input logic bank, input int addr, input logic [PW-1:0] req, input string name);
    check(shadow[{bank, AW'(addr)}] === req, name, 32'(shadow[{bank, AW'(addr)}]), 32'(req));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(wr.wr_en === 1'b0,    {tag, "_wr_en"},    32'(wr.wr_en),    32'h0);
    check(wr.wr_bank === 1'b0,  {tag, "_wr_bank"},  32'(wr.wr_bank),  32'h0);
    check(wr.wr_addr === '0,    {tag, "_wr_addr"},  32'(wr.wr_addr),  32'h0);
    check(wr.wr_data === '0,    {tag, "_wr_data"},  32'(wr.wr_data),  32'h0);
    check(wr.swap_req === 1'b0, {tag, "_swap_req"}, 32'(wr.swap_req), 32'h0);
    check(busy === 1'b0,        {tag, "_busy"},     32'(busy),        32'h0);
    check(err === 1'b0,         {tag, "_err"},      32'(err),         32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n0, s0, b0;
    bit found;
    rx = 1'b1;
    disp_bank = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check(dbg_state == IDLE, "reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    mon_en = 1'b1;

    // Lone byte: received, ignored by IDLE.
    send_byte(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check(bv_cnt == 1, "t1_bv_count", 32'(bv_cnt), 32'd1);
    check(bv_last == 8'h5A, "t1_bv_data", 32'(bv_last), 32'h5A);
    check(err === 1'b0, "t1_err", 32'(err), 32'h0);
    check(n_writes == 0, "t1_no_writes", 32'(n_writes), 32'h0);
    check(busy === 1'b0, "t1_busy", 32'(busy), 32'h0);

    // Full LOAD into bank 1.
    disp_bank = 1'b0;
    n0 = n_writes; s0 = swaps_seen; b0 = bv_cnt;
    push_load(1'b1, N_PIX / 2);
    exp_swaps = 1;
    send_byte(SYNC_BYTE, 1'b1);
    send_byte(CMD_LOAD, 1'b1);
    for (int k = 0; k < N_PIX / 2; k++) send_byte(8'(k), 1'b1);
    wait_swaps(s0 + 1, 200, "t2_swap");
    check(exp_q.size() == 0, "t2_queue_drained", 32'(exp_q.size()), 32'h0);
    check(n_writes - n0 == N_PIX, "t2_write_count", 32'(n_writes - n0), 32'(N_PIX));
    check(bv_cnt - b0 == 2 + N_PIX / 2, "t2_bv_count", 32'(bv_cnt - b0), 32'(2 + N_PIX / 2));
    repeat (2) @(negedge clk);
    check(busy === 1'b0, "t2_busy_done", 32'(busy), 32'h0);
    check(err === 1'b0, "t2_err", 32'(err), 32'h0);
    check_pix(1'b1, 0,    4'h0, "t2_pix_0");
    check_pix(1'b1, 162,  4'h5, "t2_pix_162");
    check_pix(1'b1, 163,  4'h1, "t2_pix_163");
    check_pix(1'b1, 600,  4'h2, "t2_pix_600");
    check_pix(1'b1, 601,  4'hC, "t2_pix_601");
    check_pix(1'b1, 1023, 4'hF, "t2_pix_1023");

    // FILL into bank 0; disp_bank flips mid-command and must be ignored.
    disp_bank = 1'b1;
    s0 = swaps_seen;
    push_fill(1'b0, 4'h7, N_PIX);
    exp_swaps = 1;
    first_wr_cyc = -1;
    send_byte(SYNC_BYTE, 1'b1);
    send_byte(CMD_FILL, 1'b1);
    repeat (10) @(negedge clk);
    disp_bank = 1'b0;
    send_byte(8'h37, 1'b1);
    wait_swaps(s0 + 1, 2 * N_PIX, "t3_swap");
    check(exp_q.size() == 0, "t3_queue_drained", 32'(exp_q.size()), 32'h0);
    check(last_wr_cyc - first_wr_cyc == N_PIX - 1, "t3_back_to_back",
          32'(last_wr_cyc - first_wr_cyc), 32'(N_PIX - 1));
    check_pix(1'b0, 500, 4'h7, "t3_pix_500");

    // Unknown command, then a valid FILL still completes.
    n0 = n_writes;
    send_byte(SYNC_BYTE, 1'b1);
    send_byte(8'h09, 1'b1);
    repeat (20) @(negedge clk);
    check(err === 1'b1, "t4_err", 32'(err), 32'h1);
    check(busy === 1'b0, "t4_busy", 32'(busy), 32'h0);
    check(n_writes == n0, "t4_no_writes", 32'(n_writes - n0), 32'h0);
    disp_bank = 1'b1;
    s0 = swaps_seen;
    push_fill(1'b0, 4'h3, N_PIX);
    exp_swaps = 1;
    send_byte(SYNC_BYTE, 1'b1);
    send_byte(CMD_FILL, 1'b1);
    send_byte(8'hC3, 1'b1);
    wait_swaps(s0 + 1, 2 * N_PIX, "t4_swap");
    check(exp_q.size() == 0, "t4_queue_drained", 32'(exp_q.size()), 32'h0);
    check_pix(1'b0, 700, 4'h3, "t4_pix_700");

    // Timeout partway through a LOAD.
    do_reset();
    check(err === 1'b0, "t5_err_cleared", 32'(err), 32'h0);
    disp_bank = 1'b0;
    s0 = swaps_seen;
    push_load(1'b1, 100);
    exp_swaps = 0;
    send_byte(SYNC_BYTE, 1'b1);
    send_byte(CMD_LOAD, 1'b1);
    for (int k = 0; k < 100; k++) send_byte(8'(k), 1'b1);
    repeat (TMO / 2) @(negedge clk);
    check(busy === 1'b1, "t5_busy_before_timeout", 32'(busy), 32'h1);
    check(err === 1'b0, "t5_err_before_timeout", 32'(err), 32'h0);
    repeat (TMO / 2 + 50) @(negedge clk);
    check(busy === 1'b0, "t5_busy_after_timeout", 32'(busy), 32'h0);
    check(err === 1'b1, "t5_err_after_timeout", 32'(err), 32'h1);
    check(dbg_state == IDLE, "t5_state", 32'(dbg_state), 32'(IDLE));
    check(exp_q.size() == 0, "t5_queue_drained", 32'(exp_q.size()), 32'h0);
    check(swaps_seen == s0, "t5_no_swap", 32'(swaps_seen), 32'(s0));

    // Bad stop bit mid-LOAD.
    do_reset();
    b0 = bv_cnt;
    push_load(1'b1, 3);
    send_byte(SYNC_BYTE, 1'b1);
    send_byte(CMD_LOAD, 1'b1);
    for (int k = 0; k < 3; k++) send_byte(8'(k), 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check(err === 1'b1, "t6_err", 32'(err), 32'h1);
    check(busy === 1'b0, "t6_busy", 32'(busy), 32'h0);
    check(bv_cnt - b0 == 5, "t6_bv_count", 32'(bv_cnt - b0), 32'd5);
    check(exp_q.size() == 0, "t6_queue_drained", 32'(exp_q.size()), 32'h0);

    // One-cycle reset while FILL is at address 1000.
    do_reset();
    disp_bank = 1'b0;
    s0 = swaps_seen;
    push_fill(1'b1, 4'h9, 1001);
    exp_swaps = 0;
    send_byte(SYNC_BYTE, 1'b1);
    send_byte(CMD_FILL, 1'b1);
    send_byte(8'h09, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 2 * N_PIX && !found; i++) begin
      @(negedge clk);
      if (wr.wr_en === 1'b1 && wr.wr_addr == AW'(1000)) found = 1'b1;
    end
    check(found, "t7_reached_1000", 32'(found), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t7_reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check(exp_q.size() == 0, "t7_queue_drained", 32'(exp_q.size()), 32'h0);
    check(swaps_seen == s0, "t7_no_swap", 32'(swaps_seen), 32'(s0));
    disp_bank = 1'b1;
    push_fill(1'b0, 4'hE, N_PIX);
    exp_swaps = 1;
    send_byte(SYNC_BYTE, 1'b1);
    send_byte(CMD_FILL, 1'b1);
    send_byte(8'h0E, 1'b1);
    wait_swaps(s0 + 1, 2 * N_PIX, "t7_next_swap");
    check(exp_q.size() == 0, "t7_next_queue_drained", 32'(exp_q.size()), 32'h0);
    check_pix(1'b0, 1010, 4'hE, "t7_pix_1010");

    // ---------------- final report ----------------
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
